// File: rtl/pattern_detector.sv
// pattern_detector: serial detector for a run-time programmed pattern with match counter
module pattern_detector #(
  parameter int SEQ_W = 8,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(SEQ_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [SEQ_W-1:0] seq,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             din,
  input  logic             din_valid,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;
  logic [0:0] state;
  logic [SEQ_W-1:0] pat, hist, hist_next, mask;
  logic [LEN_W-1:0] len, fill, fill_next;
  logic hit;
  assign cfg_err = (state == IDLE);
  always_comb begin
    hist_next = {hist[SEQ_W-2:0], din};
    fill_next = (fill == LEN_W'(SEQ_W)) ? fill : fill + LEN_W'(1);
    mask = ~({SEQ_W{1'b1}} << len);
    hit = din_valid && (state == ARMED) && (fill_next >= len) && (((hist_next ^ pat) & mask) == '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat <= '0;
      len <= '0;
      hist <= '0;
      fill <= '0;
      match_cnt <= '0;
      dout <= 1'b0;
    end else if (cfg_load) begin
      state <= (seq_len != '0 && seq_len <= LEN_W'(SEQ_W)) ? ARMED : IDLE;
      pat <= seq;
      len <= seq_len;
      hist <= '0;
      fill <= '0;
      match_cnt <= '0;
      dout <= 1'b0;
    end else begin
      dout <= hit;
      if (din_valid) begin
        hist <= hist_next;
        fill <= (!OVERLAP && hit) ? '0 : fill_next;
      end
      if (hit && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: three detector variants on a shared stream, scoreboarded against a bit-queue model
module tb_pattern_detector;
  localparam int SW = 8;
  logic clk = 1'b0;
  logic reset, cfg_load, din, din_valid;
  logic [7:0] seq;
  logic [3:0] seq_len;
  logic d0, d1, d2, e0, e1, e2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  always #5 clk = ~clk;

  pattern_detector #(.SEQ_W(SW), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .seq(seq), .seq_len(seq_len),
    .din(din), .din_valid(din_valid), .dout(d0), .match_cnt(c0), .cfg_err(e0));
  pattern_detector #(.SEQ_W(SW), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .seq(seq), .seq_len(seq_len),
    .din(din), .din_valid(din_valid), .dout(d1), .match_cnt(c1), .cfg_err(e1));
  pattern_detector #(.SEQ_W(SW), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .seq(seq), .seq_len(seq_len),
    .din(din), .din_valid(din_valid), .dout(d2), .match_cnt(c2), .cfg_err(e2));

  typedef struct packed {
    logic [2:0] d;
    logic [2:0] e;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
  } exp_t;
  exp_t sb[$];
  exp_t got;
  int checks = 0, fails = 0;
  bit hq[3][$];
  logic [7:0] mpat[3];
  int mlen[3];
  bit merr[3];
  int mcnt[3];
  logic [7:0] cur_seq;
  logic [3:0] cur_len;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("dout_ov", d0, got.d[0]);
      chk("dout_nov", d1, got.d[1]);
      chk("dout_sat", d2, got.d[2]);
      chk("err_ov", e0, got.e[0]);
      chk("err_nov", e1, got.e[1]);
      chk("err_sat", e2, got.e[2]);
      chk("cnt_ov", c0, got.c0);
      chk("cnt_nov", c1, got.c1);
      chk("cnt_sat", c2, got.c2);
    end
  end

  // Model: keep the valid bits seen since the last clear and compare the newest len of them to the pattern
  task automatic step(bit rs, bit cl, logic [7:0] sq, logic [3:0] ln, bit d, bit v);
    exp_t x;
    x = '0;
    reset = rs; cfg_load = cl; seq = sq; seq_len = ln; din = d; din_valid = v;
    for (int i = 0; i < 3; i++) begin
      bit m;
      int mx;
      m = 1'b0;
      mx = (i == 2) ? 3 : 255;
      if (rs) begin
        hq[i].delete(); mpat[i] = '0; mlen[i] = 0; merr[i] = 1'b1; mcnt[i] = 0;
      end else if (cl) begin
        hq[i].delete(); mpat[i] = sq; mlen[i] = int'(ln); mcnt[i] = 0;
        merr[i] = (ln == 0) || (int'(ln) > SW);
      end else if (v && !merr[i]) begin
        hq[i].push_back(d);
        if (hq[i].size() > SW) void'(hq[i].pop_front());
        if (hq[i].size() >= mlen[i]) begin
          m = 1'b1;
          for (int k = 0; k < mlen[i]; k++)
            if (hq[i][hq[i].size() - 1 - k] != mpat[i][k]) m = 1'b0;
        end
        if (m) begin
          if (mcnt[i] < mx) mcnt[i]++;
          if (i == 1) hq[i].delete();
        end
      end
      x.d[i] = m;
      x.e[i] = merr[i];
    end
    x.c0 = 8'(mcnt[0]);
    x.c1 = 8'(mcnt[1]);
    x.c2 = 2'(mcnt[2]);
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(logic [7:0] sq, logic [3:0] ln);
    step(1'b0, 1'b1, sq, ln, 1'($urandom), 1'($urandom));
  endtask

  // Seq/len wander randomly between loads; only cfg_load may latch them
  task automatic feed(logic [15:0] b, int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 8'($urandom), 4'($urandom), b[i], 1'b1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; seq = '0; seq_len = '0; din = 1'b0; din_valid = 1'b0;
    @(posedge clk);
    #2;
    step(1'b1, 1'b0, 8'hff, 4'd4, 1'b1, 1'b1);
    feed(16'b1111, 4);
    cfg(8'b1010, 4'd4);
    feed(16'b10101010, 8);
    cfg(8'b1, 4'd1);
    feed(16'b0110, 4);
    cfg(8'b1010, 4'd4);
    feed(16'b10, 2);
    idle(3);
    feed(16'b10, 2);
    idle(1);
    cfg(8'b1010, 4'd4);
    feed(16'b101, 3);
    step(1'b1, 1'b0, 8'b1010, 4'd4, 1'b0, 1'b1);
    cfg(8'b1010, 4'd4);
    feed(16'b0, 1);
    cfg(8'b1010, 4'd0);
    feed(16'b1111, 4);
    cfg(8'b1, 4'd9);
    feed(16'b1111, 4);
    cfg(8'b1, 4'd1);
    feed(16'b11111, 5);
    cfg(8'b10110011, 4'd8);
    feed(16'b1011001110110011, 16);
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) step(1'b1, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      else if (r < 4) cfg(8'($urandom), (r < 3) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 10)));
      else step(1'b0, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end
    idle(2);
    repeat (3) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
